store_write_controller: RTL and testbench
=========================================

Name: store_write_controller

Overview:
- Sequences CPU store requests (SB/SH/SW) onto the data-memory write port.
- Places the byte or halfword in the correct lanes with byte enables, and buffers up to DEPTH stores in strict program order.
- Drives a memory master with a waitrequest handshake, so the pipeline only stalls when the buffer is full.
- Sits between the MEM stage and data memory, replacing direct write-data formatting.

Parameters:
DEPTH, 2, number of FIFO entries behind the output holding register; power of two, at least 2.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  store request present
req_ready  out  1  controller can accept a request this cycle
req_op  in  6  MIPS opcode: 101000 SB, 101001 SH, 101011 SW
req_addr  in  32  byte address
req_data  in  32  rt register value; the store uses bits [7:0], [15:0] or [31:0]
mem_address  out  32  word address, bits [1:0] always 00
mem_write  out  1  write request to memory
mem_writedata  out  32  lane-replicated write data
mem_byteenable  out  4  active lanes; bit i enables bits [8i+7:8i]
mem_waitrequest  in  1  memory stall; a write completes on an edge where mem_write=1 and mem_waitrequest=0
idle  out  1  1 when the FIFO is empty and no write is in flight
store_err  out  1  one-cycle pulse: unsupported op or misaligned address dropped

Behaviour:
Reset (rst_n low, asynchronous):
- State IDLE, FIFO count 0.
- mem_write, mem_address, mem_writedata, mem_byteenable and store_err all 0.
- idle=1, req_ready=1.
- A write in flight is abandoned, and queued stores are discarded.

Handshake:
- req_ready = (FIFO count < DEPTH), driven from registered state only. It has no combinational path from req_valid or mem_waitrequest.
- A request is accepted on an edge where req_valid && req_ready && rst_n.

Formatting (let a = req_addr[1:0]):
- SB: byteenable = 0001<<a; data = {4{req_data[7:0]}}.
- SH: requires a[0]=0; byteenable = 0011<<a; data = {2{req_data[15:0]}}.
- SW: requires a=00; byteenable = 1111; data = req_data.
- In all cases the entry address is {req_addr[31:2],2'b00}.

Error handling:
- An unsupported op or a misaligned SH/SW is still accepted (handshake completes) but is not enqueued.
- store_err is 1 for exactly the cycle after the accepting edge.

FSM:
- IDLE: mem_write=0 and the FIFO is always empty. On an accepting edge with a valid store, the formatted entry bypasses the FIFO into the output registers and the state becomes WRITE. mem_write is high from that edge, giving 1-cycle latency.
- WRITE: mem_write=1. mem_address, mem_writedata and mem_byteenable stay stable while mem_waitrequest=1.
- WRITE, on the completion edge:
  - FIFO non-empty: load the head into the output registers, pop, and stay in WRITE. Writes are back-to-back with no idle cycle.
  - FIFO empty and a valid push on the same edge: bypass-load it and stay in WRITE.
  - Otherwise: go to IDLE with mem_write=0.
- While in WRITE, accepted stores push to the FIFO tail.
- A simultaneous push and pop keeps count unchanged. The head/tail pointers wrap modulo DEPTH.

Full condition:
- count == DEPTH gives req_ready=0.
- A pop on the same edge does not make req_ready=1 until the next cycle.
- Total capacity is DEPTH+1 stores, counting the holding register.

Other outputs and ordering:
- idle = (state==IDLE).
- Memory writes occur in strict acceptance order; stores are never merged or reordered.

Test Plan:
- Reset then SB addr=0x1003 data=0x000000A5, mem_waitrequest=0 -> next cycle mem_write=1, address=0x1000, writedata=0xA5A5A5A5, byteenable=1000; idle=1 one cycle later.
- SH addr=0x2002 data=0x1234BEEF -> address 0x2000, writedata 0xBEEFBEEF, byteenable 1100. SH addr=0x2001 -> store_err pulse for one cycle, no mem_write.
- mem_waitrequest held 1; send 4 SW back-to-back (0x10..0x1C) -> 3 accepted, req_ready=0 on the 4th. mem_write outputs stay stable on 0x10 throughout. Release waitrequest -> 4 writes complete in order 0x10,0x14,0x18,0x1C on consecutive cycles.
- Continuous SW stream with waitrequest=0 -> one write per cycle, req_ready stays 1, count never exceeds 1.
- op=100011 (LW) with valid -> accepted, store_err=1 for one cycle, FIFO and memory untouched.
- rst_n dropped mid-way while mem_write=1 with 2 queued entries -> mem_write=0 immediately (asynchronous). After release: idle=1, req_ready=1, no stale writes issued.

Source files
------------

// File: rtl/store_write_controller.sv
// store_write_controller: formats SB/SH/SW stores into byte lanes and issues them in order to a waitrequest memory port
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        store request handshake; ready only while the FIFO has room
//   req_op, req_addr, req_data MIPS store opcode, byte address, rt value
//   mem_address/mem_write/mem_writedata/mem_byteenable/mem_waitrequest  memory master port
//   idle                       no write in flight and nothing queued
//   store_err                  one-cycle pulse after an unsupported op or misaligned store is dropped
module store_write_controller #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic [31:0] mem_address,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    output logic        idle,
    output logic        store_err
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    typedef enum logic {IDLE, WRITE} state_t;
    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } entry_t;

    state_t        state_q, state_d;
    entry_t        out_q, out_d, fmt;
    entry_t        fifo_q [DEPTH];
    entry_t        fifo_d [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic          store_err_q, store_err_d;
    logic          is_sb, is_sh, is_sw, fmt_ok, accept, done, bypass, push, pop;
    logic [1:0]    a;

    assign a      = req_addr[1:0];
    assign is_sb  = req_op == 6'b101000;
    assign is_sh  = req_op == 6'b101001;
    assign is_sw  = req_op == 6'b101011;
    assign fmt_ok = is_sb || (is_sh && !a[0]) || (is_sw && a == 2'b00);

    assign fmt.addr = req_addr[31:2];
    assign fmt.data = is_sw ? req_data : is_sh ? {2{req_data[15:0]}} : {4{req_data[7:0]}};
    assign fmt.be   = is_sw ? 4'b1111 : ((is_sh ? 4'b0011 : 4'b0001) << a);

    assign req_ready = count_q < FULL;
    assign accept    = req_valid && req_ready;
    assign done      = state_q == WRITE && !mem_waitrequest;
    assign pop       = done && count_q != '0;
    // A valid store goes straight to the holding register when nothing is ahead of it.
    assign bypass    = accept && fmt_ok && (state_q == IDLE || (done && count_q == '0));
    assign push      = accept && fmt_ok && !bypass;

    always_comb begin
        fifo_d = fifo_q;
        if (push) fifo_d[tail_q] = fmt;
        tail_d      = push ? tail_q + PW'(1) : tail_q;
        head_d      = pop ? head_q + PW'(1) : head_q;
        count_d     = count_q + (PW + 1)'(push) - (PW + 1)'(pop);
        out_d       = bypass ? fmt : pop ? fifo_q[head_q] : out_q;
        state_d     = bypass ? WRITE : (done && count_q == '0) ? IDLE : state_q;
        store_err_d = accept && !fmt_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_q       <= '0;
            fifo_q      <= '{default: '0};
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            store_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            fifo_q      <= fifo_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            store_err_q <= store_err_d;
        end
    end

    assign mem_write      = state_q == WRITE;
    assign mem_address    = {out_q.addr, 2'b00};
    assign mem_writedata  = out_q.data;
    assign mem_byteenable = out_q.be;
    assign idle           = state_q == IDLE;
    assign store_err      = store_err_q;
endmodule

// File: tb/tb_store_write_controller.sv
// tb_store_write_controller: directed checks of store formatting, queueing, backpressure and reset
module tb_store_write_controller;
    localparam logic [5:0] SB = 6'b101000, SH = 6'b101001, SW = 6'b101011, LW = 6'b100011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_op = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [31:0] mem_address;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic        mem_waitrequest = 1'b0;
    logic        idle;
    logic        store_err;
    int          errs = 0;
    int          checks = 0;

    store_write_controller #(.DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
        .mem_address(mem_address), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_waitrequest(mem_waitrequest),
        .idle(idle), .store_err(store_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_data  = data;
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        chk({tag, ".write"}, 32'(mem_write), 32'd1);
        chk({tag, ".addr"}, mem_address, addr);
        chk({tag, ".data"}, mem_writedata, data);
        chk({tag, ".be"}, 32'(mem_byteenable), 32'(be));
    endtask

    initial begin
        #12;
        chk("rst.write", 32'(mem_write), 32'd0);
        chk("rst.addr", mem_address, 32'd0);
        chk("rst.be", 32'(mem_byteenable), 32'd0);
        chk("rst.idle", 32'(idle), 32'd1);
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.err", 32'(store_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        req(SB, 32'h1003, 32'h0000_00A5);
        step();
        req_valid = 1'b0;
        wr("sb", 32'h1000, 32'hA5A5_A5A5, 4'b1000);
        chk("sb.idle_busy", 32'(idle), 32'd0);
        step();
        chk("sb.done", 32'(mem_write), 32'd0);
        chk("sb.idle", 32'(idle), 32'd1);

        req(SH, 32'h2002, 32'h1234_BEEF);
        step();
        req_valid = 1'b0;
        wr("sh", 32'h2000, 32'hBEEF_BEEF, 4'b1100);
        step();
        req(SH, 32'h2001, 32'h1234_BEEF);
        step();
        req_valid = 1'b0;
        chk("sh_mis.err", 32'(store_err), 32'd1);
        chk("sh_mis.write", 32'(mem_write), 32'd0);
        step();
        chk("sh_mis.err_off", 32'(store_err), 32'd0);
        chk("sh_mis.write2", 32'(mem_write), 32'd0);

        mem_waitrequest = 1'b1;
        req(SW, 32'h10, 32'hA0A0_0010);
        step();
        wr("bp0", 32'h10, 32'hA0A0_0010, 4'b1111);
        chk("bp0.ready", 32'(req_ready), 32'd1);
        req(SW, 32'h14, 32'hA0A0_0014);
        step();
        chk("bp1.ready", 32'(req_ready), 32'd1);
        req(SW, 32'h18, 32'hA0A0_0018);
        step();
        chk("bp2.ready", 32'(req_ready), 32'd0);
        req(SW, 32'h1C, 32'hA0A0_001C);
        for (int i = 0; i < 3; i++) begin
            step();
            wr("bp_hold", 32'h10, 32'hA0A0_0010, 4'b1111);
            chk("bp_hold.ready", 32'(req_ready), 32'd0);
        end
        mem_waitrequest = 1'b0;
        step();
        wr("drain1", 32'h14, 32'hA0A0_0014, 4'b1111);
        chk("drain1.ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        wr("drain2", 32'h18, 32'hA0A0_0018, 4'b1111);
        step();
        wr("drain3", 32'h1C, 32'hA0A0_001C, 4'b1111);
        step();
        chk("drain.end", 32'(mem_write), 32'd0);
        chk("drain.idle", 32'(idle), 32'd1);

        for (int i = 0; i < 5; i++) begin
            req(SW, 32'h100 + 32'(4 * i), 32'hC000_0000 + 32'(i));
            step();
            wr("stream", 32'h100 + 32'(4 * i), 32'hC000_0000 + 32'(i), 4'b1111);
            chk("stream.ready", 32'(req_ready), 32'd1);
        end
        req_valid = 1'b0;
        step();
        chk("stream.idle", 32'(idle), 32'd1);

        req(LW, 32'h300, 32'h1111_1111);
        step();
        req_valid = 1'b0;
        chk("lw.err", 32'(store_err), 32'd1);
        chk("lw.write", 32'(mem_write), 32'd0);
        chk("lw.idle", 32'(idle), 32'd1);
        step();
        chk("lw.err_off", 32'(store_err), 32'd0);
        chk("lw.write2", 32'(mem_write), 32'd0);

        mem_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req(SW, 32'h200 + 32'(4 * i), 32'hD000_0000 + 32'(i));
            step();
        end
        req_valid = 1'b0;
        wr("pre_rst", 32'h200, 32'hD000_0000, 4'b1111);
        chk("pre_rst.ready", 32'(req_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async.write", 32'(mem_write), 32'd0);
        chk("async.idle", 32'(idle), 32'd1);
        chk("async.ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        mem_waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst.write", 32'(mem_write), 32'd0);
            chk("post_rst.idle", 32'(idle), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
